// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Captures the decoded instruction from ID and presents it to EX, the
// forwarding unit and the load-hazard unit. Arbitrates stall, flush and
// load-use hazards, drives the front-end enables and keeps saturating
// counters of inserted bubbles.
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic              id_rw,
  input  logic              id_mem_rd,
  input  logic              id_mem_wr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              load_hazard,
  input  logic              ex_flush,
  input  logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1_addr,
  output logic [4:0]        ex_rs2_addr,
  output logic [4:0]        ex_rd_addr,
  output logic              ex_rw,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              pc_en,
  output logic              if_id_en,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // RUN: normal operation. HOLD_FLUSH: a flush arrived while the pipe was
  // stalled and must be applied on the first unstalled edge.
  typedef enum logic [0:0] {
    ST_RUN        = 1'b0,
    ST_HOLD_FLUSH = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Saturating increment: all-ones is sticky so the counter never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (&value) begin
      result = value;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  // EX slot registers
  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_pc;
  logic [XLEN-1:0]   r_ex_rs1_data;
  logic [XLEN-1:0]   r_ex_rs2_data;
  logic [XLEN-1:0]   r_ex_imm;
  logic [4:0]        r_ex_rs1_addr;
  logic [4:0]        r_ex_rs2_addr;
  logic [4:0]        r_ex_rd_addr;
  logic              r_ex_rw;
  logic              r_ex_mem_rd;
  logic              r_ex_mem_wr;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  // Decision signals produced by the control process
  logic w_flush_pending;
  logic w_load;
  logic w_bubble;
  logic w_bubble_inc;
  logic w_flush_inc;
  logic w_pc_en;
  logic w_if_id_en;

  // Decode whether the current state carries a deferred flush.
  always_comb begin
    w_flush_pending = 1'b0;
    case (r_state)
      ST_RUN:        w_flush_pending = 1'b0;
      ST_HOLD_FLUSH: w_flush_pending = 1'b1;
      default:       w_flush_pending = 1'b0;
    endcase
  end

  // Priority arbitration: stall, then flush (live or deferred), then load-use, then pass-through.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_bubble     = 1'b0;
    w_bubble_inc = 1'b0;
    w_flush_inc  = 1'b0;
    w_pc_en      = 1'b1;
    w_if_id_en   = 1'b1;
    if (stall) begin
      // Whole front end frozen; remember a flush so it is not lost.
      w_pc_en    = 1'b0;
      w_if_id_en = 1'b0;
      if (ex_flush) begin
        w_state_nxt = ST_HOLD_FLUSH;
      end else begin
        w_state_nxt = r_state;
      end
    end else if (ex_flush || w_flush_pending) begin
      // Squash the ID instruction; a pending hazard is irrelevant now.
      w_state_nxt = ST_RUN;
      w_load      = 1'b1;
      w_bubble    = 1'b1;
      w_flush_inc = id_valid;
    end else if (load_hazard) begin
      // Insert a bubble and freeze IF/ID so the dependent instruction replays.
      w_load       = 1'b1;
      w_bubble     = 1'b1;
      w_bubble_inc = id_valid;
      w_pc_en      = 1'b0;
      w_if_id_en   = 1'b0;
    end else begin
      // Normal advance; an empty ID slot enters EX as a bubble.
      w_load   = 1'b1;
      w_bubble = ~id_valid;
    end
  end

  // State register for the deferred-flush FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand and address fields; their contents are don't-care inside a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_pc       <= {XLEN{1'b0}};
      r_ex_rs1_data <= {XLEN{1'b0}};
      r_ex_rs2_data <= {XLEN{1'b0}};
      r_ex_imm      <= {XLEN{1'b0}};
      r_ex_rs1_addr <= 5'd0;
      r_ex_rs2_addr <= 5'd0;
    end else if (w_load) begin
      r_ex_pc       <= id_pc;
      r_ex_rs1_data <= id_rs1_data;
      r_ex_rs2_data <= id_rs2_data;
      r_ex_imm      <= id_imm;
      r_ex_rs1_addr <= id_rs1_addr;
      r_ex_rs2_addr <= id_rs2_addr;
    end else begin
      r_ex_pc       <= r_ex_pc;
      r_ex_rs1_data <= r_ex_rs1_data;
      r_ex_rs2_data <= r_ex_rs2_data;
      r_ex_imm      <= r_ex_imm;
      r_ex_rs1_addr <= r_ex_rs1_addr;
      r_ex_rs2_addr <= r_ex_rs2_addr;
    end
  end

  // Control fields; forced to zero in a bubble so rd=0 never matches in hazard/forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_rd_addr <= 5'd0;
      r_ex_rw      <= 1'b0;
      r_ex_mem_rd  <= 1'b0;
      r_ex_mem_wr  <= 1'b0;
      r_ex_ctrl    <= {CTRL_W{1'b0}};
    end else if (w_load && w_bubble) begin
      r_ex_valid   <= 1'b0;
      r_ex_rd_addr <= 5'd0;
      r_ex_rw      <= 1'b0;
      r_ex_mem_rd  <= 1'b0;
      r_ex_mem_wr  <= 1'b0;
      r_ex_ctrl    <= {CTRL_W{1'b0}};
    end else if (w_load) begin
      r_ex_valid   <= 1'b1;
      r_ex_rd_addr <= id_rd_addr;
      r_ex_rw      <= id_rw;
      r_ex_mem_rd  <= id_mem_rd;
      r_ex_mem_wr  <= id_mem_wr;
      r_ex_ctrl    <= id_ctrl;
    end else begin
      r_ex_valid   <= r_ex_valid;
      r_ex_rd_addr <= r_ex_rd_addr;
      r_ex_rw      <= r_ex_rw;
      r_ex_mem_rd  <= r_ex_mem_rd;
      r_ex_mem_wr  <= r_ex_mem_wr;
      r_ex_ctrl    <= r_ex_ctrl;
    end
  end

  // Saturating performance counters; at most one step each per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= {CNT_W{1'b0}};
      r_flush_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (w_bubble_inc) begin
        r_bubble_cnt <= sat_inc(r_bubble_cnt);
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
      if (w_flush_inc) begin
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_pc       = r_ex_pc;
  assign ex_rs1_data = r_ex_rs1_data;
  assign ex_rs2_data = r_ex_rs2_data;
  assign ex_imm      = r_ex_imm;
  assign ex_rs1_addr = r_ex_rs1_addr;
  assign ex_rs2_addr = r_ex_rs2_addr;
  assign ex_rd_addr  = r_ex_rd_addr;
  assign ex_rw       = r_ex_rw;
  assign ex_mem_rd   = r_ex_mem_rd;
  assign ex_mem_wr   = r_ex_mem_wr;
  assign ex_ctrl     = r_ex_ctrl;
  assign bubble_cnt  = r_bubble_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign pc_en       = w_pc_en;
  assign if_id_en    = w_if_id_en;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios plus randomized
// traffic, compared against a transaction-level model of the EX slot.
// A second instance with 2-bit counters exercises saturation.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = 32'd0, id_rs1_data = 32'd0, id_rs2_data = 32'd0, id_imm = 32'd0;
  logic [4:0]  id_rs1_addr = 5'd0, id_rs2_addr = 5'd0, id_rd_addr = 5'd0;
  logic        id_rw = 1'b0, id_mem_rd = 1'b0, id_mem_wr = 1'b0;
  logic [7:0]  id_ctrl = 8'd0;
  logic        load_hazard = 1'b0, ex_flush = 1'b0, stall = 1'b0;

  logic        ex_valid, ex_rw, ex_mem_rd, ex_mem_wr, pc_en, if_id_en;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [7:0]  ex_ctrl;
  logic [15:0] bubble_cnt, flush_cnt;

  logic        s_valid, s_rw, s_mem_rd, s_mem_wr, s_pc_en, s_if_id_en;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1_addr, s_rs2_addr, s_rd_addr;
  logic [7:0]  s_ctrl;
  logic [1:0]  s_bubble_cnt, s_flush_cnt;

  id_ex_stage_reg #(.XLEN(32), .CTRL_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rw(id_rw), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_ctrl(id_ctrl),
    .load_hazard(load_hazard), .ex_flush(ex_flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr),
    .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_rw(ex_rw),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_ctrl(ex_ctrl),
    .pc_en(pc_en), .if_id_en(if_id_en), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage_reg #(.XLEN(32), .CTRL_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rw(id_rw), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_ctrl(id_ctrl),
    .load_hazard(load_hazard), .ex_flush(ex_flush), .stall(stall),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_rs1_data(s_rs1_data),
    .ex_rs2_data(s_rs2_data), .ex_imm(s_imm), .ex_rs1_addr(s_rs1_addr),
    .ex_rs2_addr(s_rs2_addr), .ex_rd_addr(s_rd_addr), .ex_rw(s_rw),
    .ex_mem_rd(s_mem_rd), .ex_mem_wr(s_mem_wr), .ex_ctrl(s_ctrl),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the instruction the EX slot should hold, a deferred-flush
  // flag, and unbounded event counts that are clipped to each counter width.
  typedef struct {
    logic v; logic [31:0] pc, r1, r2, imm; logic [4:0] a1, a2, rd;
    logic rw, mr, mw; logic [7:0] ctrl;
  } ex_t;
  ex_t m_ex;
  logic m_pend;
  int m_bcnt, m_fcnt;

  function automatic int clip(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic logic exp_front_en();
    if (stall) return 1'b0;
    if (ex_flush || m_pend) return 1'b1;
    if (load_hazard) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_ex = '{default: '0};
    m_pend = 1'b0;
    m_bcnt = 0;
    m_fcnt = 0;
  endtask

  task automatic model_bubble();
    m_ex.v = 1'b0; m_ex.rd = 5'd0; m_ex.rw = 1'b0;
    m_ex.mr = 1'b0; m_ex.mw = 1'b0; m_ex.ctrl = 8'd0;
  endtask

  task automatic model_edge();
    if (stall) begin
      if (ex_flush) m_pend = 1'b1;
    end else if (ex_flush || m_pend) begin
      m_pend = 1'b0;
      model_bubble();
      if (id_valid) m_fcnt++;
    end else if (load_hazard) begin
      model_bubble();
      if (id_valid) m_bcnt++;
    end else begin
      m_ex.v = id_valid; m_ex.pc = id_pc; m_ex.r1 = id_rs1_data; m_ex.r2 = id_rs2_data;
      m_ex.imm = id_imm; m_ex.a1 = id_rs1_addr; m_ex.a2 = id_rs2_addr;
      m_ex.rd = id_rd_addr; m_ex.rw = id_rw; m_ex.mr = id_mem_rd; m_ex.mw = id_mem_wr;
      m_ex.ctrl = id_ctrl;
      if (!id_valid) model_bubble();
    end
  endtask

  task automatic check_regs();
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex.v});
    check("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, m_ex.rd});
    check("ex_ctl_bits", {29'd0, ex_rw, ex_mem_rd, ex_mem_wr}, {29'd0, m_ex.rw, m_ex.mr, m_ex.mw});
    check("ex_ctrl", {24'd0, ex_ctrl}, {24'd0, m_ex.ctrl});
    if (m_ex.v) begin
      check("ex_pc", ex_pc, m_ex.pc);
      check("ex_rs1_data", ex_rs1_data, m_ex.r1);
      check("ex_rs2_data", ex_rs2_data, m_ex.r2);
      check("ex_imm", ex_imm, m_ex.imm);
      check("ex_rs_addrs", {22'd0, ex_rs1_addr, ex_rs2_addr}, {22'd0, m_ex.a1, m_ex.a2});
    end
    check("bubble_cnt", {16'd0, bubble_cnt}, clip(m_bcnt, 65535));
    check("flush_cnt", {16'd0, flush_cnt}, clip(m_fcnt, 65535));
    check("sat_bubble_cnt", {30'd0, s_bubble_cnt}, clip(m_bcnt, 3));
    check("sat_flush_cnt", {30'd0, s_flush_cnt}, clip(m_fcnt, 3));
    check("sat_ex_rd_addr", {27'd0, s_rd_addr}, {27'd0, m_ex.rd});
  endtask

  // Fresh random instruction payload in ID.
  task automatic rand_payload();
    id_pc = $urandom & 32'hFFFF_FFFC; id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_imm = $urandom; id_rs1_addr = 5'($urandom); id_rs2_addr = 5'($urandom);
    id_rd_addr = 5'($urandom); id_rw = 1'($urandom); id_mem_rd = 1'($urandom);
    id_mem_wr = 1'($urandom); id_ctrl = 8'($urandom);
  endtask

  task automatic set_ctl(input logic v, input logic lh, input logic fl, input logic st);
    id_valid = v; load_hazard = lh; ex_flush = fl; stall = st;
  endtask

  // One clock: inputs already driven after a falling edge.
  task automatic cycle();
    #1;
    check("pc_en", {31'd0, pc_en}, {31'd0, exp_front_en()});
    check("if_id_en", {31'd0, if_id_en}, {31'd0, exp_front_en()});
    check("sat_pc_en", {31'd0, s_pc_en}, {31'd0, exp_front_en()});
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges, checked before any edge occurs.
  task automatic do_reset();
    @(negedge clk);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_ex_data", ex_rs1_data | ex_rs2_data | ex_imm, 32'd0);
    check("rst_ex_addrs", {17'd0, ex_rs1_addr, ex_rs2_addr, ex_rd_addr}, 32'd0);
    check("rst_ex_ctl", {21'd0, ex_rw, ex_mem_rd, ex_mem_wr, ex_ctrl}, 32'd0);
    check("rst_counters", {bubble_cnt, flush_cnt}, 32'd0);
    check("rst_sat_counters", {28'd0, s_bubble_cnt, s_flush_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_pc_en", {31'd0, pc_en}, 32'd1);
    check("rst_if_id_en", {31'd0, if_id_en}, 32'd1);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    #12 rst = 1'b0;

    // Reset with asynchronous assertion
    do_reset();

    // Pass-through of a real instruction
    rand_payload();
    id_pc = 32'h100; id_rd_addr = 5'd5; id_rw = 1'b1;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    check("t2_ex_pc", ex_pc, 32'h100);
    check("t2_ex_rd", {27'd0, ex_rd_addr}, 32'd5);
    check("t2_ex_rw_valid", {30'd0, ex_rw, ex_valid}, 32'd3);

    // Load-use bubble
    rand_payload(); id_rd_addr = 5'd7; id_rw = 1'b1;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    check("t3_bubble_rd", {27'd0, ex_rd_addr}, 32'd0);
    check("t3_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);

    // Flush takes priority over load-use
    do_reset();
    rand_payload();
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0);
    cycle();
    check("t4_counts", {bubble_cnt, flush_cnt}, 32'h0000_0001);

    // Flush arriving during a 3-cycle stall is deferred to the release edge
    do_reset();
    rand_payload(); set_ctl(1'b1, 1'b0, 1'b0, 1'b0); cycle();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1); cycle();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1); cycle();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1); cycle();
    check("t5_held_valid", {31'd0, ex_valid}, 32'd1);
    check("t5_flush_pending_cnt", {16'd0, flush_cnt}, 32'd0);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0); cycle();
    check("t5_bubble", {31'd0, ex_valid}, 32'd0);
    check("t5_flush_cnt", {16'd0, flush_cnt}, 32'd1);

    // Reset while a flush is pending discards it
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1); cycle();
    do_reset();
    rand_payload(); set_ctl(1'b1, 1'b0, 1'b0, 1'b0); cycle();
    check("pend_cleared_valid", {31'd0, ex_valid}, 32'd1);

    // Counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rand_payload(); set_ctl(1'b1, 1'b1, 1'b0, 1'b0); cycle();
    end
    check("t6_sat_bubble", {30'd0, s_bubble_cnt}, 32'd3);
    check("t6_wide_bubble", {16'd0, bubble_cnt}, 32'd5);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      rand_payload();
      set_ctl(1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 99) < 25),
              1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 25));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
